alu_issue: RTL



---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_issue_if.sv | 16 +
 rtl/operand_fwd.sv | 32 +++
 rtl/alu_issue.sv | 104 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, default widths and flag layout
package alu_pkg;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_REG_AW = 4;
   typedef enum logic [2:0] {
      ADD    = 3'b000,
      PADDSB = 3'b001,
      SUB    = 3'b010,
      AND    = 3'b011,
      NOR    = 3'b100,
      SLL    = 3'b101,
      SRL    = 3'b110,
      SRA    = 3'b111
   } alu_op_e;
   localparam int FLAG_ZR  = 0;
   localparam int FLAG_OV  = 1;
   localparam int FLAG_NEG = 2;
   typedef struct packed {
      logic neg;
      logic ov;
      logic zr;
   } alu_flags_t;
endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: issue-to-ALU valid/ready operand bus
interface alu_issue_if import alu_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW
);
   logic              valid;
   logic              ready;
   logic [2:0]        aluop;
   logic [DATA_W-1:0] src0;
   logic [DATA_W-1:0] src1;
   logic [REG_AW-1:0] rd;
   logic              we;
   logic              is_load;
   modport master(output valid, aluop, src0, src1, rd, we, is_load, input ready);
   modport slave(input valid, aluop, src0, src1, rd, we, is_load, output ready);
endinterface

// File: rtl/operand_fwd.sv
// operand_fwd: dependency match and mem/wb/stored select for one source operand
// ALU_ISSUE_FORWARD_EN enables the mem bypass leg.
module operand_fwd #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4
) (
   input  logic [REG_AW-1:0] idx,
   input  logic              chk,
   input  logic [DATA_W-1:0] stored,
   input  logic              mem_we,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_is_load,
   input  logic [DATA_W-1:0] mem_result,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic              mem_hit,
   output logic              wb_hit,
   output logic [DATA_W-1:0] value
);
   logic live;
   assign live    = chk && idx != '0;
   assign mem_hit = live && mem_we && idx == mem_rd;
   assign wb_hit  = live && wb_we && idx == wb_rd;
`ifdef ALU_ISSUE_FORWARD_EN
   assign value = (mem_hit && !mem_is_load) ? mem_result : wb_hit ? wb_data : stored;
`else
   logic unused_mem;
   assign unused_mem = mem_is_load ^ (^mem_result);
   assign value = wb_hit ? wb_data : stored;
`endif
endmodule

// File: rtl/alu_issue.sv
// alu_issue: single-entry issue register feeding the ALU with bypass, load-use stall and flush
// Define ALU_ISSUE_FORWARD_EN for the combinational mem bypass; otherwise mem matches stall.
module alu_issue import alu_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [2:0]        id_aluop,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              id_use_imm,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_we,
   input  logic              id_is_load,
   input  logic              flush,
   alu_issue_if.master       ex,
   input  logic              mem_we,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_is_load,
   input  logic [DATA_W-1:0] mem_result,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data
);
   logic              held, we_q, ld_q, ui_q;
   logic [2:0]        op_q;
   logic [REG_AW-1:0] rs_q, rt_q, rd_q;
   logic [DATA_W-1:0] op0, op1, src0, src1, cap0, cap1;
   logic              mh0, mh1, wh0, wh1, hazard, accept, consume;

   operand_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd0 (
      .idx(rs_q), .chk(1'b1), .stored(op0),
      .mem_we(mem_we), .mem_rd(mem_rd), .mem_is_load(mem_is_load), .mem_result(mem_result),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .mem_hit(mh0), .wb_hit(wh0), .value(src0)
   );

   operand_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd1 (
      .idx(rt_q), .chk(!ui_q), .stored(op1),
      .mem_we(mem_we), .mem_rd(mem_rd), .mem_is_load(mem_is_load), .mem_result(mem_result),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .mem_hit(mh1), .wb_hit(wh1), .value(src1)
   );

`ifdef ALU_ISSUE_FORWARD_EN
   assign hazard = held && mem_is_load && (mh0 || mh1);
`else
   assign hazard = held && (mh0 || mh1);
`endif

   assign ex.valid   = held && !hazard;
   assign consume    = ex.valid && ex.ready;
   assign id_ready   = !held || consume;
   assign accept     = id_valid && id_ready;
   assign ex.aluop   = op_q;
   assign ex.src0    = src0;
   assign ex.src1    = src1;
   assign ex.rd      = rd_q;
   assign ex.we      = we_q;
   assign ex.is_load = ld_q;

   // capture through the wb port so a same-cycle writeback is not lost
   assign cap0 = (wb_we && id_rs != '0 && id_rs == wb_rd) ? wb_data : id_rs_data;
   assign cap1 = id_use_imm ? id_imm : (wb_we && id_rt != '0 && id_rt == wb_rd) ? wb_data : id_rt_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held <= 1'b0;
         op_q <= '0;
         rs_q <= '0;
         rt_q <= '0;
         rd_q <= '0;
         we_q <= 1'b0;
         ld_q <= 1'b0;
         ui_q <= 1'b0;
         op0  <= '0;
         op1  <= '0;
      end else if (flush) begin
         held <= 1'b0;
      end else if (accept) begin
         held <= 1'b1;
         op_q <= id_aluop;
         rs_q <= id_rs;
         rt_q <= id_rt;
         rd_q <= id_rd;
         we_q <= id_we;
         ld_q <= id_is_load;
         ui_q <= id_use_imm;
         op0  <= cap0;
         op1  <= cap1;
      end else if (consume) begin
         held <= 1'b0;
      end else if (held) begin
         op0 <= wh0 ? wb_data : op0;
         op1 <= wh1 ? wb_data : op1;
      end
   end
endmodule
